reaction_ctrl: RTL and testbench

Control FSM for the human reaction timer; sits directly upstream of `time_count` and drives its `time_clr` / `time_en` inputs. It arms a trial on a debounced start pulse and waits a pseudo-random delay. It then lights the GO LED and enables the counter until the player's stop pulse or the counter's `time_late` flag. Early presses, late timeouts and valid results are reported as flags for the display logic.

---
 rtl/reaction_pkg.sv | 66 ++++++
 rtl/lfsr16.sv | 40 ++++
 rtl/reaction_ctrl.sv | 124 ++++++++++++
 tb/tb_reaction_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// reaction_pkg: shared types and helpers for the reaction timer control path.
//   state_t          - control FSM states
//   ctrl_out_t       - packed bundle of the FSM's decoded outputs
//   LFSR_TAPS        - Galois tap mask for x^16+x^14+x^13+x^11+1
//   delay_w()        - width of the wait counter for a given parameter set
//   decode_outputs() - Moore output decode for a state
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT,
        GO,
        DONE,
        EARLY,
        LATE
    } state_t;

    typedef struct packed {
        logic time_clr;
        logic time_en;
        logic led_go;
        logic early;
        logic late;
        logic result_valid;
        logic busy;
    } ctrl_out_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Wide enough for DELAY_MIN plus the largest random extra wait.
    function automatic int unsigned delay_w(input int unsigned dmin,
                                            input int unsigned span_bits);
        return $clog2(dmin + (32'd1 << span_bits));
    endfunction

    function automatic ctrl_out_t decode_outputs(input state_t s);
        ctrl_out_t o;
        o = '0;
        case (s)
            IDLE:  o.time_clr = 1'b1;
            ARM: begin
                o.time_clr = 1'b1;
                o.busy     = 1'b1;
            end
            WAIT: begin
                o.time_clr = 1'b1;
                o.busy     = 1'b1;
            end
            GO: begin
                o.time_en = 1'b1;
                o.led_go  = 1'b1;
                o.busy    = 1'b1;
            end
            DONE:  o.result_valid = 1'b1;
            EARLY: begin
                o.early    = 1'b1;
                o.time_clr = 1'b1;
            end
            LATE:  o.late = 1'b1;
            default: o.time_clr = 1'b1;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1).
// Only compiled when REACTION_CTRL_RANDOM_EN is defined; the fixed-delay
// build of reaction_ctrl has no use for it.
//   clk - system clock
//   rst - asynchronous active-high reset, loads SEED
//   q   - current LFSR state (never zero for a nonzero SEED)
`ifdef REACTION_CTRL_RANDOM_EN
module lfsr16
    import reaction_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Right-shifting Galois form: feedback bit is the LSB shifted out.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule
`endif

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: control FSM for the human reaction timer. Arms on start,
// waits a (pseudo-random) number of ticks, lights GO and enables time_count
// until stop or time_late, then reports done / early / late.
// Build option: REACTION_CTRL_RANDOM_EN selects an LFSR-derived wait;
// otherwise the wait is fixed at DELAY_MIN + 2^(DELAY_SPAN_BITS-1).
//   clk, rst     - clock, asynchronous active-high reset
//   tick         - 1 kHz single-cycle enable
//   start, stop  - debounced single-cycle button pulses
//   time_late    - counter overflow flag from time_count
//   time_clr/en  - time_count clear / enable
//   led_go, early, late, result_valid, busy - status to lamp and display
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned DELAY_MIN       = 1000,
    parameter int unsigned DELAY_SPAN_BITS = 11,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic start,
    input  logic stop,
    input  logic time_late,
    output logic time_clr,
    output logic time_en,
    output logic led_go,
    output logic early,
    output logic late,
    output logic result_valid,
    output logic busy
);

    localparam int unsigned DELAY_W = delay_w(DELAY_MIN, DELAY_SPAN_BITS);

    state_t               state_q, state_d;
    logic [DELAY_W-1:0]   delay_cnt_q, delay_cnt_d;
    logic [DELAY_W-1:0]   delay_load;
    ctrl_out_t            out_q, out_d;

    // Wait length loaded in ARM.
`ifdef REACTION_CTRL_RANDOM_EN
    logic [15:0] lfsr_q;
    logic        unused_lfsr;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign delay_load  = DELAY_W'(DELAY_MIN) + DELAY_W'(lfsr_q[DELAY_SPAN_BITS-1:0]);
    assign unused_lfsr = ^lfsr_q;
`else
    localparam int unsigned DELAY_FIXED = DELAY_MIN + ((32'd1 << DELAY_SPAN_BITS) >> 1);

    logic unused_seed;

    assign delay_load  = DELAY_W'(DELAY_FIXED);
    assign unused_seed = ^LFSR_SEED;
`endif

    // Next-state, wait counter and output decode.
    always_comb begin
        state_d     = state_q;
        delay_cnt_d = delay_cnt_q;
        case (state_q)
            IDLE, DONE, EARLY, LATE: begin
                if (start) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                delay_cnt_d = delay_load;
                state_d     = WAIT;
            end
            WAIT: begin
                if (tick && (delay_cnt_q != '0)) begin
                    delay_cnt_d = delay_cnt_q - DELAY_W'(1);
                end
                // A press in the same cycle as expiry still counts as early.
                if (stop) begin
                    state_d = EARLY;
                end else if (delay_cnt_q == '0) begin
                    state_d = GO;
                end
            end
            GO: begin
                if (stop) begin
                    state_d = DONE;
                end else if (time_late) begin
                    state_d = LATE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registering the decode of the next state gives Moore timing with
        // glitch-free outputs.
        out_d = decode_outputs(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            delay_cnt_q <= '0;
            out_q       <= decode_outputs(IDLE);
        end else begin
            state_q     <= state_d;
            delay_cnt_q <= delay_cnt_d;
            out_q       <= out_d;
        end
    end

    assign time_clr     = out_q.time_clr;
    assign time_en      = out_q.time_en;
    assign led_go       = out_q.led_go;
    assign early        = out_q.early;
    assign late         = out_q.late;
    assign result_valid = out_q.result_valid;
    assign busy         = out_q.busy;

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb_reaction_ctrl: self-checking bench for reaction_ctrl with DELAY_MIN=4,
// DELAY_SPAN_BITS=2. Works with or without REACTION_CTRL_RANDOM_EN; the wait
// length window widens from the fixed 6 ticks to 4..7 when it is defined.
module tb_reaction_ctrl;

    localparam int DMIN = 4;
    localparam int SPAN = 2;
`ifdef REACTION_CTRL_RANDOM_EN
    localparam int WAIT_LO = DMIN;
    localparam int WAIT_HI = DMIN + (1 << SPAN) - 1;
`else
    localparam int WAIT_LO = DMIN + (1 << (SPAN - 1));
    localparam int WAIT_HI = WAIT_LO;
`endif

    // Output vector order: {time_clr, time_en, led_go, early, late, result_valid, busy}
    localparam logic [6:0] O_IDLE  = 7'b1000000;
    localparam logic [6:0] O_ARM   = 7'b1000001;
    localparam logic [6:0] O_WAIT  = 7'b1000001;
    localparam logic [6:0] O_GO    = 7'b0110001;
    localparam logic [6:0] O_DONE  = 7'b0000010;
    localparam logic [6:0] O_EARLY = 7'b1001000;
    localparam logic [6:0] O_LATE  = 7'b0000100;

    logic clk = 1'b0;
    logic rst, tick, start, stop, time_late;
    logic time_clr, time_en, led_go, early, late, result_valid, busy;
    logic [6:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    reaction_ctrl #(
        .DELAY_MIN       (DMIN),
        .DELAY_SPAN_BITS (SPAN),
        .LFSR_SEED       (16'hACE1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .start        (start),
        .stop         (stop),
        .time_late    (time_late),
        .time_clr     (time_clr),
        .time_en      (time_en),
        .led_go       (led_go),
        .early        (early),
        .late         (late),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    assign obs = {time_clr, time_en, led_go, early, late, result_valid, busy};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start and advance until GO; e = edges after the start edge.
    task automatic run_to_go(output int e);
        start = 1'b1;
        step();
        start = 1'b0;
        e = 0;
        while (led_go !== 1'b1 && e < 100) begin
            step();
            e++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b1; start = 1'b0; stop = 1'b0; time_late = 1'b0;
        repeat (3) step();
        n_tests++;
        if (obs !== O_IDLE) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs, O_IDLE);
        end
        rst = 1'b0;
        step();
        n_tests++;
        if (obs !== O_IDLE) begin
            n_fail++; $display("FAIL reset_idle_hold: got %b expected %b", obs, O_IDLE);
        end
    endtask

    task automatic test_nominal();
        int e;
        int hold;
        start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if (obs !== O_ARM) begin
            n_fail++; $display("FAIL nominal_arm: got %b expected %b", obs, O_ARM);
        end
        e = 0;
        do begin
            step();
            e++;
            if (led_go !== 1'b1) begin
                n_tests++;
                if (obs !== O_WAIT) begin
                    n_fail++; $display("FAIL nominal_wait_e%0d: got %b expected %b", e, obs, O_WAIT);
                end
            end
        end while (led_go !== 1'b1 && e < 100);
        n_tests++;
        if (e - 2 < WAIT_LO || e - 2 > WAIT_HI) begin
            n_fail++; $display("FAIL nominal_go_edge: got %0d expected %0d..%0d", e, WAIT_LO + 2, WAIT_HI + 2);
        end
        hold = $urandom_range(4, 0);
        repeat (hold) step();
        n_tests++;
        if (obs !== O_GO) begin
            n_fail++; $display("FAIL nominal_go_hold: got %b expected %b", obs, O_GO);
        end
        stop = 1'b1; step(); stop = 1'b0;
        n_tests++;
        if (obs !== O_DONE) begin
            n_fail++; $display("FAIL nominal_done: got %b expected %b", obs, O_DONE);
        end
        stop = 1'b1; time_late = 1'b1; step(); stop = 1'b0; time_late = 1'b0;
        n_tests++;
        if (obs !== O_DONE) begin
            n_fail++; $display("FAIL done_ignores_stop: got %b expected %b", obs, O_DONE);
        end
    endtask

    task automatic test_early();
        int k;
        int e;
        logic en_seen;
        logic clr_low;
        for (int i = 0; i < 5; i++) begin
            k = (i == 0) ? 3 : (i == 1) ? WAIT_LO + 2 : (i == 2) ? 2 : $urandom_range(WAIT_LO + 2, 2);
            en_seen = 1'b0;
            clr_low = 1'b0;
            start = 1'b1; step(); start = 1'b0;
            for (int j = 1; j <= k; j++) begin
                stop = (j == k);
                step();
                en_seen = en_seen | time_en;
                clr_low = clr_low | ~time_clr;
            end
            stop = 1'b0;
            n_tests++;
            if (obs !== O_EARLY || en_seen !== 1'b0 || clr_low !== 1'b0) begin
                n_fail++; $display("FAIL early_k%0d: got %b en_seen %b clr_low %b expected %b 0 0",
                                   k, obs, en_seen, clr_low, O_EARLY);
            end
        end
        stop = 1'b1; step(); stop = 1'b0;
        n_tests++;
        if (obs !== O_EARLY) begin
            n_fail++; $display("FAIL early_ignores_stop: got %b expected %b", obs, O_EARLY);
        end
        // Stop while ARM is not a valid press and must be ignored.
        start = 1'b1; step(); start = 1'b0;
        stop = 1'b1; step(); stop = 1'b0;
        n_tests++;
        if (obs !== O_WAIT) begin
            n_fail++; $display("FAIL arm_ignores_stop: got %b expected %b", obs, O_WAIT);
        end
        e = 1;
        while (led_go !== 1'b1 && e < 100) begin
            step();
            e++;
        end
        n_tests++;
        if (e - 2 < WAIT_LO || e - 2 > WAIT_HI) begin
            n_fail++; $display("FAIL arm_stop_go_edge: got %0d expected %0d..%0d", e, WAIT_LO + 2, WAIT_HI + 2);
        end
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic test_late();
        int e;
        run_to_go(e);
        n_tests++;
        if (led_go !== 1'b1) begin
            n_fail++; $display("FAIL late_reach_go: got %b expected 1", led_go);
        end
        repeat ($urandom_range(3, 0)) step();
        time_late = 1'b1; step();
        n_tests++;
        if (obs !== O_LATE) begin
            n_fail++; $display("FAIL late_flag: got %b expected %b", obs, O_LATE);
        end
        stop = 1'b1; step(); stop = 1'b0;
        n_tests++;
        if (obs !== O_LATE) begin
            n_fail++; $display("FAIL late_ignores_stop: got %b expected %b", obs, O_LATE);
        end
        time_late = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        n_tests++;
        if (obs !== O_ARM) begin
            n_fail++; $display("FAIL late_restart_arm: got %b expected %b", obs, O_ARM);
        end
    endtask

    task automatic test_stop_and_late();
        int e;
        run_to_go(e);
        stop = 1'b1; time_late = 1'b1; step(); stop = 1'b0; time_late = 1'b0;
        n_tests++;
        if (obs !== O_DONE) begin
            n_fail++; $display("FAIL stop_late_same: got %b expected %b", obs, O_DONE);
        end
    endtask

    task automatic test_start_ignored();
        int e;
        start = 1'b1; step(); start = 1'b0;
        repeat (3) step();
        start = 1'b1; step(); start = 1'b0;
        e = 4;
        n_tests++;
        if (obs !== O_WAIT) begin
            n_fail++; $display("FAIL wait_ignores_start: got %b expected %b", obs, O_WAIT);
        end
        while (led_go !== 1'b1 && e < 100) begin
            step();
            e++;
        end
        n_tests++;
        if (e - 2 < WAIT_LO || e - 2 > WAIT_HI) begin
            n_fail++; $display("FAIL start_ignored_go_edge: got %0d expected %0d..%0d", e, WAIT_LO + 2, WAIT_HI + 2);
        end
        start = 1'b1; step(); start = 1'b0;
        n_tests++;
        if (obs !== O_GO) begin
            n_fail++; $display("FAIL go_ignores_start: got %b expected %b", obs, O_GO);
        end
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    // Random tick pattern: GO must follow the edge after the D-th sampled tick.
    task automatic test_random_tick();
        int e;
        int ticks;
        logic cur;
        logic last;
        for (int t = 0; t < 3; t++) begin
            ticks = 0;
            last  = 1'b0;
            tick  = 1'b1;
            start = 1'b1; step(); start = 1'b0;
            e = 0;
            do begin
                cur  = 1'($urandom_range(1, 0));
                tick = cur;
                step();
                e++;
                if (led_go !== 1'b1 && e >= 2) begin
                    ticks = ticks + int'(cur);
                    last  = cur;
                end
            end while (led_go !== 1'b1 && e < 300);
            n_tests++;
            if (led_go !== 1'b1 || ticks < WAIT_LO || ticks > WAIT_HI || last !== 1'b1) begin
                n_fail++; $display("FAIL random_tick_t%0d: got go %b ticks %0d last %b expected go 1 ticks %0d..%0d last 1",
                                   t, led_go, ticks, last, WAIT_LO, WAIT_HI);
            end
            tick = 1'b1;
            stop = 1'b1; step(); stop = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        int e;
        run_to_go(e);
        n_tests++;
        if (obs !== O_GO) begin
            n_fail++; $display("FAIL async_pre_go: got %b expected %b", obs, O_GO);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (obs !== O_IDLE) begin
            n_fail++; $display("FAIL async_reset_immediate: got %b expected %b", obs, O_IDLE);
        end
        #1;
        rst = 1'b0;
        step();
        n_tests++;
        if (obs !== O_IDLE) begin
            n_fail++; $display("FAIL async_reset_idle: got %b expected %b", obs, O_IDLE);
        end
    endtask

    task automatic test_delays();
        int e;
        int w;
        logic [15:0] seen;
        seen = '0;
        for (int t = 0; t < 20; t++) begin
            repeat ($urandom_range(7, 0)) step();
            run_to_go(e);
            w = e - 2;
            n_tests++;
            if (w < WAIT_LO || w > WAIT_HI) begin
                n_fail++; $display("FAIL delay_range_t%0d: got %0d expected %0d..%0d", t, w, WAIT_LO, WAIT_HI);
            end
            if (w >= 0 && w < 16) begin
                seen[w] = 1'b1;
            end
            stop = 1'b1; step(); stop = 1'b0;
        end
`ifdef REACTION_CTRL_RANDOM_EN
        n_tests++;
        if ($countones(seen) < 2) begin
            n_fail++; $display("FAIL delay_distinct: got %0d expected >=2", $countones(seen));
        end
`else
        n_tests++;
        if (seen !== (16'h0001 << WAIT_LO)) begin
            n_fail++; $display("FAIL delay_fixed_set: got %h expected %h", seen, 16'h0001 << WAIT_LO);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_early();
        test_late();
        test_stop_and_late();
        test_start_ignored();
        test_random_tick();
        test_async_reset();
        test_delays();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
